// File: rtl/uart_rx_deserializer_if.sv
// Serial-side and parallel-side signals of the UART receive deserializer.
//   RX_IN      : serial line, idle high, synchronous to the receiver clock
//   PAR_EN     : 1 = frame carries a parity bit after the data bits
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   P_DATA     : last good received word
//   Data_Valid : one-cycle pulse, P_DATA holds a new good word
//   Par_Err    : one-cycle pulse, parity mismatch on the frame just received
//   Stp_Err    : one-cycle pulse, stop bit sampled as 0
// master = line/config driver and result consumer, slave = the receiver.
interface uart_rx_deserializer_if #(
  parameter int OUT_WIDTH = 8
);
  logic                 RX_IN;
  logic                 PAR_EN;
  logic                 PAR_TYP;
  logic [OUT_WIDTH-1:0] P_DATA;
  logic                 Data_Valid;
  logic                 Par_Err;
  logic                 Stp_Err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, Par_Err, Stp_Err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, Par_Err, Stp_Err
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: start bit, OUT_WIDTH data bits LSB first,
// optional parity bit, one stop bit, each bit OVERSAMPLE clocks long.
// Each bit is the majority of three samples around the bit centre.
// Ports:
//   CLK : clock, all state updates on the rising edge
//   RST : asynchronous active-low reset
//   bus : uart_rx_deserializer_if.slave (serial input, parity config,
//         parallel word and result pulses)
module uart_rx_deserializer #(
  parameter int OUT_WIDTH  = 8,
  parameter int OVERSAMPLE = 8
) (
  input logic                    CLK,
  input logic                    RST,
  uart_rx_deserializer_if.slave  bus
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BCW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  localparam logic [CW-1:0]  E_LO   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  E_MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0]  E_HI   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0]  E_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(OUT_WIDTH - 1);

  generate
    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_oversample
      $error("OVERSAMPLE must be even and at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        edge_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [OUT_WIDTH-1:0] shift_reg;
  logic                 samp_lo;
  logic                 samp_mid;
  logic                 par_en_q;
  logic                 par_typ_q;
  logic                 par_fail;

  logic                 maj;
  logic                 at_decide;
  logic                 at_last;
  logic [CW-1:0]        edge_next;
  logic                 par_expect;

  // Third sample is the live input at the decision edge.
  always_comb begin
    maj        = (samp_lo & samp_mid) | (samp_lo & bus.RX_IN) | (samp_mid & bus.RX_IN);
    at_decide  = (edge_cnt == E_HI);
    at_last    = (edge_cnt == E_LAST);
    edge_next  = at_last ? '0 : edge_cnt + 1'b1;
    par_expect = (^shift_reg) ^ par_typ_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      edge_cnt       <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      samp_lo        <= 1'b0;
      samp_mid       <= 1'b0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      par_fail       <= 1'b0;
      bus.P_DATA     <= '0;
      bus.Data_Valid <= 1'b0;
      bus.Par_Err    <= 1'b0;
      bus.Stp_Err    <= 1'b0;
    end else begin
      bus.Data_Valid <= 1'b0;
      bus.Par_Err    <= 1'b0;
      bus.Stp_Err    <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= edge_next;
        if (edge_cnt == E_LO)  samp_lo  <= bus.RX_IN;
        if (edge_cnt == E_MID) samp_mid <= bus.RX_IN;
      end

      case (state)
        IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          par_fail <= 1'b0;
          if (!bus.RX_IN) begin
            // The low cycle seen here is edge 0 of the start bit.
            state     <= START;
            edge_cnt  <= CW'(1);
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
          end
        end

        START: begin
          if (at_decide && maj) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (at_last) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (at_decide) shift_reg[bit_cnt] <= maj;
          if (at_last) begin
            if (bit_cnt == B_LAST) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (at_decide && (maj != par_expect)) par_fail <= 1'b1;
          if (at_last) state <= STOP;
        end

        STOP: begin
          if (at_decide) begin
            bus.Stp_Err <= ~maj;
            bus.Par_Err <= par_fail;
            if (maj && !par_fail) begin
              bus.P_DATA     <= shift_reg;
              bus.Data_Valid <= 1'b1;
            end
          end
          if (at_last) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer with default parameters
// (8 data bits, 8 clocks per bit). Cycle k is the clock period that
// follows the k-th rising edge; inputs are driven and pulses are timed
// in those terms, so a frame whose start bit begins in cycle T produces
// its result pulse in cycle T+78 (no parity) or T+86 (with parity).
module tb_uart_rx_deserializer;

  localparam int OS = 8;

  logic clk;
  logic rst_n;
  int   cyc;

  int   vectors;
  int   miscompares;

  // Pulse bookkeeping filled in by the negedge monitor.
  int          dv_cnt, pe_cnt, se_cnt;
  int          dv_first, dv_last, pe_last, se_last;
  logic [7:0]  dv_data_first, dv_data_last;
  int          bad_hold;
  logic [7:0]  prev_pdata;

  uart_rx_deserializer_if #(.OUT_WIDTH(8)) bus ();

  uart_rx_deserializer #(
    .OUT_WIDTH (8),
    .OVERSAMPLE(OS)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bad_hold   = 0;
    prev_pdata = '0;
  end

  always @(negedge clk) begin
    if (bus.Data_Valid === 1'b1) begin
      if (dv_cnt == 0) begin
        dv_first      = cyc;
        dv_data_first = bus.P_DATA;
      end
      dv_cnt       = dv_cnt + 1;
      dv_last      = cyc;
      dv_data_last = bus.P_DATA;
    end
    if (bus.Par_Err === 1'b1) begin
      pe_cnt  = pe_cnt + 1;
      pe_last = cyc;
    end
    if (bus.Stp_Err === 1'b1) begin
      se_cnt  = se_cnt + 1;
      se_last = cyc;
    end
    if (rst_n === 1'b1 && bus.Data_Valid !== 1'b1 && bus.P_DATA !== prev_pdata)
      bad_hold = bad_hold + 1;
    prev_pdata = bus.P_DATA;
  end

  task automatic clear_mon();
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0;
    dv_first = -1; dv_last = -1; pe_last = -1; se_last = -1;
    dv_data_first = '0; dv_data_last = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.RX_IN = b;
    tick(OS);
  endtask

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    tick(n);
  endtask

  // Start bit begins in the current cycle, returned as t0.
  task automatic send_frame(input logic [7:0] data, input logic with_par,
                            input logic par_bit, input logic stop_bit,
                            input logic flip_cfg, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    if (flip_cfg) begin
      bus.PAR_EN  = ~bus.PAR_EN;
      bus.PAR_TYP = ~bus.PAR_TYP;
    end
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (with_par) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.RX_IN   = 1'b1;
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      bus.RX_IN = i[0];
      tick(1);
      vectors++;
      if ({bus.P_DATA, bus.Data_Valid, bus.Par_Err, bus.Stp_Err} !== 11'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %0h expected 0", i,
                 {bus.P_DATA, bus.Data_Valid, bus.Par_Err, bus.Stp_Err});
      end
    end
    bus.RX_IN = 1'b1;
    rst_n     = 1'b1;
    idle(20);
    vectors++;
    if (dv_cnt + pe_cnt + se_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_no_pulses: got %0d pulses expected 0", dv_cnt + pe_cnt + se_cnt);
    end
  endtask

  task automatic test_good_frame();
    int t0;
    clear_mon();
    bus.PAR_EN = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    idle(4);
    vectors++;
    if (bus.P_DATA !== 8'hA5) begin
      miscompares++;
      $display("FAIL good_pdata: got %0h expected a5", bus.P_DATA);
    end
    vectors++;
    if (dv_cnt !== 1 || dv_last !== t0 + 78) begin
      miscompares++;
      $display("FAIL good_dv_timing: got count %0d at %0d expected 1 at %0d",
               dv_cnt, dv_last - t0, 78);
    end
    vectors++;
    if (pe_cnt + se_cnt !== 0) begin
      miscompares++;
      $display("FAIL good_no_err: got %0d expected 0", pe_cnt + se_cnt);
    end
  endtask

  task automatic test_parity();
    int t0;
    // 0x5A has four ones: even parity bit is 0.
    clear_mon();
    bus.PAR_EN  = 1'b1;
    bus.PAR_TYP = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, t0);
    idle(4);
    vectors++;
    if (pe_cnt !== 1 || pe_last !== t0 + 86) begin
      miscompares++;
      $display("FAIL par_err_pulse: got count %0d at %0d expected 1 at 86", pe_cnt, pe_last - t0);
    end
    vectors++;
    if (dv_cnt !== 0 || se_cnt !== 0) begin
      miscompares++;
      $display("FAIL par_err_others: got dv %0d se %0d expected 0 0", dv_cnt, se_cnt);
    end
    vectors++;
    if (bus.P_DATA !== 8'hA5) begin
      miscompares++;
      $display("FAIL par_err_hold: got %0h expected a5", bus.P_DATA);
    end

    clear_mon();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, t0);
    idle(4);
    vectors++;
    if (dv_cnt !== 1 || dv_last !== t0 + 86 || pe_cnt !== 0) begin
      miscompares++;
      $display("FAIL par_ok_dv: got dv %0d at %0d pe %0d expected 1 at 86 pe 0",
               dv_cnt, dv_last - t0, pe_cnt);
    end
    vectors++;
    if (bus.P_DATA !== 8'h5A) begin
      miscompares++;
      $display("FAIL par_ok_pdata: got %0h expected 5a", bus.P_DATA);
    end
  endtask

  task automatic test_par_capture();
    int t0;
    // Odd parity of 0x0F is 1; config flips to no-parity after the start bit.
    clear_mon();
    bus.PAR_EN  = 1'b1;
    bus.PAR_TYP = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, t0);
    idle(4);
    vectors++;
    if (dv_cnt !== 1 || dv_last !== t0 + 86 || pe_cnt + se_cnt !== 0) begin
      miscompares++;
      $display("FAIL par_capture: got dv %0d at %0d errs %0d expected 1 at 86 errs 0",
               dv_cnt, dv_last - t0, pe_cnt + se_cnt);
    end
    vectors++;
    if (bus.P_DATA !== 8'h0F) begin
      miscompares++;
      $display("FAIL par_capture_pdata: got %0h expected 0f", bus.P_DATA);
    end
  endtask

  task automatic test_stop_error();
    int t0;
    clear_mon();
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    idle(4);
    vectors++;
    if (se_cnt !== 1 || se_last !== t0 + 78) begin
      miscompares++;
      $display("FAIL stop_err_pulse: got count %0d at %0d expected 1 at 78", se_cnt, se_last - t0);
    end
    vectors++;
    if (dv_cnt !== 0 || pe_cnt !== 0 || bus.P_DATA !== 8'h0F) begin
      miscompares++;
      $display("FAIL stop_err_hold: got dv %0d pe %0d pdata %0h expected 0 0 0f",
               dv_cnt, pe_cnt, bus.P_DATA);
    end

    // Parity and stop both bad: both error pulses in one cycle.
    clear_mon();
    bus.PAR_EN = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, t0);
    idle(4);
    vectors++;
    if (pe_cnt !== 1 || se_cnt !== 1 || pe_last !== t0 + 86 || se_last !== t0 + 86 || dv_cnt !== 0) begin
      miscompares++;
      $display("FAIL both_err: got pe %0d@%0d se %0d@%0d dv %0d expected 1@86 1@86 0",
               pe_cnt, pe_last - t0, se_cnt, se_last - t0, dv_cnt);
    end
    vectors++;
    if (bad_hold !== 0 || bus.P_DATA !== 8'h0F) begin
      miscompares++;
      $display("FAIL pdata_hold: got %0d stray changes pdata %0h expected 0 0f", bad_hold, bus.P_DATA);
    end
    bus.PAR_EN = 1'b0;
  endtask

  task automatic test_glitch();
    int t0;
    clear_mon();
    bus.RX_IN = 1'b0;
    tick(2);
    idle(30);
    vectors++;
    if (dv_cnt + pe_cnt + se_cnt !== 0) begin
      miscompares++;
      $display("FAIL glitch_no_pulse: got %0d expected 0", dv_cnt + pe_cnt + se_cnt);
    end
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    idle(4);
    vectors++;
    if (dv_cnt !== 1 || dv_last !== t0 + 78 || bus.P_DATA !== 8'h81) begin
      miscompares++;
      $display("FAIL glitch_then_frame: got dv %0d at %0d pdata %0h expected 1 at 78 81",
               dv_cnt, dv_last - t0, bus.P_DATA);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    logic [7:0] d;
    // 0x77 aborted by reset partway through data bit 3.
    clear_mon();
    d = 8'h77;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    bus.RX_IN = d[3];
    tick(4);
    rst_n     = 1'b0;
    bus.RX_IN = 1'b1;
    tick(3);
    rst_n = 1'b1;
    idle(12);
    vectors++;
    if (dv_cnt + pe_cnt + se_cnt !== 0 || bus.P_DATA !== 8'h00) begin
      miscompares++;
      $display("FAIL abort: got %0d pulses pdata %0h expected 0 00", dv_cnt + pe_cnt + se_cnt, bus.P_DATA);
    end

    clear_mon();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, t1);
    idle(4);
    vectors++;
    if (t1 - t0 !== 80 || dv_cnt !== 2 || dv_first !== t0 + 78 || dv_last !== t0 + 158) begin
      miscompares++;
      $display("FAIL b2b_timing: got count %0d first %0d last %0d expected 2 78 158",
               dv_cnt, dv_first - t0, dv_last - t0);
    end
    vectors++;
    if (dv_data_first !== 8'h01 || dv_data_last !== 8'hFE || bus.P_DATA !== 8'hFE) begin
      miscompares++;
      $display("FAIL b2b_data: got %0h then %0h expected 01 then fe", dv_data_first, dv_data_last);
    end
    vectors++;
    if (pe_cnt + se_cnt !== 0) begin
      miscompares++;
      $display("FAIL b2b_no_err: got %0d expected 0", pe_cnt + se_cnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_good_frame();
    test_parity();
    test_par_capture();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
